// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter/sequencer for the shared data-memory port used by cpu0
// and cpu1. One transaction at a time: latch the winner's request, strobe
// the memory for one cycle, wait for ready (bounded by a watchdog), then
// return a one-cycle done (with err on timeout) to the owner.
module mem_port_arbiter #(
    parameter int ADDR_W  = 13,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              mem_rdy,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [7:0] TMO = 8'(TIMEOUT);

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              prio_q, prio_d;
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              win;

    // Next-state: arbitration in IDLE, strobe in ISSUE, watchdog in WAIT,
    // pointer hand-off in DONE. err_d only rises on the transition into DONE,
    // so err_q is high exactly for the DONE cycle of a timed-out access.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        prio_d  = prio_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        win     = prio_q;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    win     = (req0 && req1) ? prio_q : req1;
                    owner_d = win;
                    we_d    = win ? we1 : we0;
                    addr_d  = win ? addr1 : addr0;
                    wdata_d = win ? wdata1 : wdata0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // A ready in the same cycle the watchdog expires wins.
                if (mem_rdy) begin
                    if (!we_q) rdata_d = mem_rdata;
                    state_d = DONE;
                end else begin
                    if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
                    if (cnt_d == TMO) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                prio_d  = ~owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and latch registers; reset aborts any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            prio_q  <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
            we_q    <= we_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decode registered state only; no input reaches an output.
    assign mem_re    = (state_q == ISSUE) && !we_q;
    assign mem_we    = (state_q == ISSUE) && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign gnt0      = (state_q != IDLE) && !owner_q;
    assign gnt1      = (state_q != IDLE) && owner_q;
    assign done0     = (state_q == DONE) && !owner_q;
    assign done1     = (state_q == DONE) && owner_q;
    assign rdata     = rdata_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: each request pushes its expected
// strobe and completion; a monitor pops and compares as the DUT produces them.
module tb_mem_port_arbiter;

    localparam int AW  = 13;
    localparam int DW  = 16;
    localparam int TMO = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          mem_rdy;
    logic [DW-1:0] mem_rdata;
    logic          mem_re, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          gnt0, gnt1, done0, done1;
    logic [DW-1:0] rdata;
    logic          err;

    typedef struct {
        logic          owner;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } iss_t;

    typedef struct {
        logic          owner;
        logic          err;
        logic [DW-1:0] rdata;
        int            lat;
    } done_t;

    iss_t          exp_iss[$];
    done_t         exp_done[$];
    logic [DW-1:0] rsp_q[$];

    int            n_chk, n_err, cyc, stb_cyc, rsp_delay, kick_req;
    int            rdy_cnt, kick_seen;
    logic [DW-1:0] rdy_data;
    bit            rsp_en;
    logic [DW-1:0] model_rd;
    iss_t          m_e;
    done_t         m_d;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .mem_rdy(mem_rdy), .mem_rdata(mem_rdata),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata(rdata), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, {mem_re, mem_we, mem_addr, mem_wdata, gnt0, gnt1, done0, done1, rdata, err}, 64'h0);
    endtask

    // Expected results derive from the requester's view: read data comes from
    // the responder queue, writes and timeouts leave the last read data.
    task automatic push_exp(input logic o, input logic w, input logic [AW-1:0] a,
                            input logic [DW-1:0] wd, input logic [DW-1:0] rd, input logic tmo);
        iss_t  e;
        done_t d;
        e.owner = o; e.we = w; e.addr = a; e.wdata = wd;
        exp_iss.push_back(e);
        if (!tmo) begin
            rsp_q.push_back(rd);
            if (!w) model_rd = rd;
        end
        d.owner = o; d.err = tmo; d.rdata = model_rd;
        d.lat   = tmo ? TMO + 1 : rsp_delay + 1;
        exp_done.push_back(d);
    endtask

    task automatic do_req(input logic cpu, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input logic [DW-1:0] rd, input logic tmo);
        bit seen;
        seen = 1'b0;
        push_exp(cpu, w, a, wd, rd, tmo);
        @(negedge clk);
        if (cpu) begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = wd; end
        else     begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = wd; end
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (cpu ? done1 : done0) seen = 1'b1;
        end
        chk("done_wait", seen, 1);
        if (cpu) req1 = 1'b0; else req0 = 1'b0;
    endtask

    // Both CPUs request continuously; grants must alternate starting at cpu0.
    task automatic rr(input int n);
        int n0, n1, guard;
        n0 = 0; n1 = 0; guard = 0;
        for (int k = 0; k < n; k++) begin
            push_exp(1'b0, 1'b0, AW'(13'h0010 + k), '0, DW'(16'hC000 + k), 1'b0);
            push_exp(1'b1, 1'b1, AW'(13'h0020 + k), DW'(16'h1234 + k), '0, 1'b0);
        end
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0; addr0 = 13'h0010; wdata0 = '0;
        req1 = 1'b1; we1 = 1'b1; addr1 = 13'h0020; wdata1 = 16'h1234;
        while (!(n0 == n && n1 == n) && guard < 400) begin
            @(negedge clk);
            guard++;
            if (done0) begin
                n0++;
                addr0 = AW'(13'h0010 + n0);
                if (n0 == n) req0 = 1'b0;
            end
            if (done1) begin
                n1++;
                addr1  = AW'(13'h0020 + n1);
                wdata1 = DW'(16'h1234 + n1);
                if (n1 == n) req1 = 1'b0;
            end
        end
        chk("rr_n0", n0, n);
        chk("rr_n1", n1, n);
    endtask

    // Async reset mid-cycle: outputs must clear immediately; bench state too.
    task automatic apply_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        #1;
        chk_zero("rst_async");
        exp_iss.delete();
        exp_done.delete();
        rsp_q.delete();
        model_rd = '0;
        @(posedge clk);
        @(negedge clk);
        chk_zero("rst_hold");
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        mem_rdy = 0; mem_rdata = '0;
        n_chk = 0; n_err = 0; cyc = 0; stb_cyc = 0; rsp_delay = 3; kick_req = 0;
        rdy_cnt = 0; kick_seen = 0; rdy_data = '0; rsp_en = 1'b1; model_rd = '0;

        fork
            // Memory responder: ready rsp_delay cycles after a strobe, or on a kick.
            begin : responder
                forever begin
                    @(posedge clk);
                    #1;
                    mem_rdy = 1'b0;
                    if (rdy_cnt > 0) begin
                        rdy_cnt--;
                        if (rdy_cnt == 0) begin mem_rdy = 1'b1; mem_rdata = rdy_data; end
                    end
                    if (rsp_en && (mem_re || mem_we) && rsp_q.size() != 0) begin
                        rdy_data = rsp_q.pop_front();
                        rdy_cnt  = rsp_delay;
                    end
                    if (kick_req != kick_seen) begin
                        kick_seen = kick_req;
                        mem_rdy   = 1'b1;
                        mem_rdata = 16'h7777;
                    end
                end
            end
            // Monitor: compare strobes and completions against the scoreboard.
            begin : monitor
                forever begin
                    @(negedge clk);
                    cyc++;
                    if (!rst) begin
                        if (gnt0 && gnt1) chk("gnt_both", 1, 0);
                        if (err && !(done0 || done1)) chk("err_nodone", 1, 0);
                        if (mem_re || mem_we) begin
                            if (exp_iss.size() == 0) chk("unexp_strobe", 1, 0);
                            else begin
                                m_e = exp_iss.pop_front();
                                chk("strobe_re", mem_re, !m_e.we);
                                chk("strobe_we", mem_we, m_e.we);
                                chk("mem_addr", mem_addr, m_e.addr);
                                if (m_e.we) chk("mem_wdata", mem_wdata, m_e.wdata);
                                chk("gnt_issue", {gnt1, gnt0}, m_e.owner ? 2'b10 : 2'b01);
                                stb_cyc = cyc;
                            end
                        end
                        if (done0 || done1) begin
                            if (exp_done.size() == 0) chk("unexp_done", {done1, done0}, 0);
                            else begin
                                m_d = exp_done.pop_front();
                                chk("done_owner", {done1, done0}, m_d.owner ? 2'b10 : 2'b01);
                                chk("gnt_done", {gnt1, gnt0}, m_d.owner ? 2'b10 : 2'b01);
                                chk("err", err, m_d.err);
                                chk("rdata", rdata, m_d.rdata);
                                chk("latency", cyc - stb_cyc, m_d.lat);
                            end
                        end
                    end
                end
            end
        join_none

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_zero("rst_state");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single write from cpu1 (returned data must not be captured), then read from cpu0.
        rsp_delay = 3;
        do_req(1'b1, 1'b1, 13'h1FFF, 16'hA5A5, 16'h5555, 1'b0);
        do_req(1'b0, 1'b0, 13'h0123, 16'h0000, 16'hBEEF, 1'b0);

        // Round-robin from reset, minimum memory latency.
        apply_reset();
        rsp_delay = 1;
        rr(2);

        // Watchdog expiry, then ready exactly on the last WAIT cycle.
        rsp_en = 1'b0;
        do_req(1'b0, 1'b0, 13'h0055, '0, '0, 1'b1);
        rsp_en = 1'b1;
        rsp_delay = TMO;
        do_req(1'b1, 1'b0, 13'h0AAA, '0, 16'h3C3C, 1'b0);
        rsp_delay = 2;
        do_req(1'b0, 1'b0, 13'h0002, '0, 16'h0F0F, 1'b0);

        // Reset during WAIT of a cpu0 read; late ready must be ignored.
        rsp_en = 1'b0;
        push_exp(1'b0, 1'b0, 13'h0ABC, '0, '0, 1'b1);
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0; addr0 = 13'h0ABC;
        for (int i = 0; i < 20 && exp_iss.size() != 0; i++) @(negedge clk);
        chk("mid_issue", exp_iss.size(), 0);
        @(negedge clk);
        chk("mid_wait_gnt", {gnt1, gnt0}, 2'b01);
        apply_reset();
        @(negedge clk);
        kick_req++;
        repeat (3) @(negedge clk);
        chk_zero("post_rdy");
        rsp_en = 1'b1;
        rsp_delay = 2;
        rr(1);
        do_req(1'b1, 1'b0, 13'h1234, '0, 16'h9999, 1'b0);

        repeat (3) @(negedge clk);
        chk("sb_empty", exp_iss.size() + exp_done.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
